// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard decoder: frame FSM states,
// prefix bytes, default scan-code entries and a parity helper.
// Entries are 9 bits wide: {extended, scan[7:0]}.
package ps2_pkg;

  // Receive frame FSM states.
  typedef enum logic [1:0] {
    PS2_IDLE   = 2'd0,
    PS2_DATA   = 2'd1,
    PS2_PARITY = 2'd2,
    PS2_STOP   = 2'd3
  } ps2_state_e;

  // Prefix bytes that qualify the following scan byte.
  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  // Scan-code entries ({ext, scan}) for the default key map.
  localparam logic [8:0] PS2_SC_SPACE = 9'h029;
  localparam logic [8:0] PS2_SC_C     = 9'h021;
  localparam logic [8:0] PS2_SC_UP    = 9'h175;
  localparam logic [8:0] PS2_SC_DOWN  = 9'h172;
  localparam logic [8:0] PS2_SC_LEFT  = 9'h16B;
  localparam logic [8:0] PS2_SC_RIGHT = 9'h174;

  // Odd parity over the data byte plus the parity bit: valid when the
  // total count of ones is odd.
  function automatic logic ps2_odd_parity_ok(input logic [7:0] data,
                                             input logic       par);
    return ^{data, par};
  endfunction

endpackage : ps2_pkg

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: synchronises the asynchronous PS/2
// lines, detects falling edges of ps2_clk, shifts in the 11-bit frame and
// reports one byte (or one error) per frame. Both reports are single-cycle
// and combinational in the cycle the closing edge is detected.
// Optional feature: define PS2_PARITY_CHECK_EN to reject bytes with bad
// odd parity; otherwise the parity bit is sampled and ignored.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned SYNC_STAGES    = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_data_o,
  output logic       byte_err_o
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] dat_sync_q;
  logic                   clk_prev_q;
  logic                   clk_s;
  logic                   dat_s;
  logic                   fall;

  ps2_state_e             state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic                   tmo_expired;
  logic                   byte_valid;
  logic                   byte_err;

`ifdef PS2_PARITY_CHECK_EN
  logic                   par_q, par_d;
`endif

  assign clk_s = clk_sync_q[SYNC_STAGES-1];
  assign dat_s = dat_sync_q[SYNC_STAGES-1];
  assign fall  = clk_prev_q & ~clk_s;

  // Synchroniser chains and previous synced clock; idle-high on reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_dat_i};
      clk_prev_q <= clk_s;
    end
  end

  // Inter-edge timeout: runs only while inside a frame, cleared by each edge.
  always_comb begin
    tmo_d       = tmo_q;
    tmo_expired = 1'b0;
    if (state_q == PS2_IDLE || fall) begin
      tmo_d = '0;
    end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
      tmo_expired = 1'b1;
      tmo_d       = '0;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  // Frame FSM: start bit, 8 data bits LSB first, parity, stop.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    byte_valid = 1'b0;
    byte_err   = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    par_d      = par_q;
`endif
    unique case (state_q)
      PS2_IDLE: begin
        if (fall && !dat_s) begin
          state_d   = PS2_DATA;
          bit_cnt_d = '0;
        end
      end
      PS2_DATA: begin
        if (fall) begin
          shift_d = {dat_s, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = PS2_PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      PS2_PARITY: begin
        if (fall) begin
`ifdef PS2_PARITY_CHECK_EN
          par_d = dat_s;
`endif
          state_d = PS2_STOP;
        end
      end
      PS2_STOP: begin
        if (fall) begin
          state_d = PS2_IDLE;
          if (!dat_s) begin
            byte_err = 1'b1;
`ifdef PS2_PARITY_CHECK_EN
          end else if (!ps2_odd_parity_ok(shift_q, par_q)) begin
            byte_err = 1'b1;
`endif
          end else begin
            byte_valid = 1'b1;
          end
        end
      end
      default: state_d = PS2_IDLE;
    endcase
    // Expiry only fires on a cycle without an edge, so it never races
    // a completed byte.
    if (tmo_expired) begin
      state_d  = PS2_IDLE;
      byte_err = 1'b1;
    end
  end

  // Frame state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= PS2_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tmo_q     <= '0;
`ifdef PS2_PARITY_CHECK_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tmo_q     <= tmo_d;
`ifdef PS2_PARITY_CHECK_EN
      par_q     <= par_d;
`endif
    end
  end

  assign byte_valid_o = byte_valid;
  assign byte_data_o  = shift_q;
  assign byte_err_o   = byte_err;

endmodule : ps2_rx_frame

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder top: receives bytes from ps2_rx_frame, folds the
// E0/F0 prefixes into a completed scan code, and tracks held/pressed/
// released state for a configurable table of keys.
// Optional feature: PS2_PARITY_CHECK_EN (odd-parity checking in ps2_rx_frame).
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned             N_KEYS         = 6,
  parameter logic [N_KEYS*9-1:0]     KEY_CODES      = {PS2_SC_SPACE, PS2_SC_C,
                                                       PS2_SC_UP,    PS2_SC_DOWN,
                                                       PS2_SC_LEFT,  PS2_SC_RIGHT},
  parameter int unsigned             TIMEOUT_CYCLES = 50000,
  parameter int unsigned             SYNC_STAGES    = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ps2_clk,
  input  logic              ps2_dat,
  output logic [N_KEYS-1:0] key_down,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic              code_valid,
  output logic [7:0]        code_data,
  output logic              code_ext,
  output logic              code_break,
  output logic              frame_err
);

  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_err;

  logic              ext_q, ext_d;
  logic              brk_q, brk_d;
  logic [N_KEYS-1:0] key_down_q, key_down_d;
  logic [N_KEYS-1:0] key_press_q, key_press_d;
  logic [N_KEYS-1:0] key_release_q, key_release_d;
  logic              code_valid_q, code_valid_d;
  logic [7:0]        code_data_q, code_data_d;
  logic              code_ext_q, code_ext_d;
  logic              code_break_q, code_break_d;
  logic              frame_err_q, frame_err_d;

  ps2_rx_frame #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_rx (
    .clk_i        (clk),
    .rst_i        (reset),
    .ps2_clk_i    (ps2_clk),
    .ps2_dat_i    (ps2_dat),
    .byte_valid_o (byte_valid),
    .byte_data_o  (byte_data),
    .byte_err_o   (byte_err)
  );

  // Prefix tracking, code completion and per-key make/break state.
  always_comb begin
    ext_d         = ext_q;
    brk_d         = brk_q;
    key_down_d    = key_down_q;
    key_press_d   = '0;
    key_release_d = '0;
    code_valid_d  = 1'b0;
    code_data_d   = code_data_q;
    code_ext_d    = code_ext_q;
    code_break_d  = code_break_q;
    frame_err_d   = 1'b0;
    if (byte_err) begin
      frame_err_d = 1'b1;
      ext_d       = 1'b0;
      brk_d       = 1'b0;
    end else if (byte_valid) begin
      if (byte_data == PS2_PREFIX_EXT) begin
        ext_d = 1'b1;
      end else if (byte_data == PS2_PREFIX_BRK) begin
        brk_d = 1'b1;
      end else begin
        code_valid_d = 1'b1;
        code_data_d  = byte_data;
        code_ext_d   = ext_q;
        code_break_d = brk_q;
        ext_d        = 1'b0;
        brk_d        = 1'b0;
        for (int unsigned i = 0; i < N_KEYS; i++) begin
          if ({ext_q, byte_data} == KEY_CODES[i*9 +: 9]) begin
            if (brk_q) begin
              if (key_down_q[i]) begin
                key_down_d[i]    = 1'b0;
                key_release_d[i] = 1'b1;
              end
            end else if (!key_down_q[i]) begin
              key_down_d[i]  = 1'b1;
              key_press_d[i] = 1'b1;
            end
          end
        end
      end
    end
  end

  // Decoder state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      ext_q         <= 1'b0;
      brk_q         <= 1'b0;
      key_down_q    <= '0;
      key_press_q   <= '0;
      key_release_q <= '0;
      code_valid_q  <= 1'b0;
      code_data_q   <= '0;
      code_ext_q    <= 1'b0;
      code_break_q  <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      ext_q         <= ext_d;
      brk_q         <= brk_d;
      key_down_q    <= key_down_d;
      key_press_q   <= key_press_d;
      key_release_q <= key_release_d;
      code_valid_q  <= code_valid_d;
      code_data_q   <= code_data_d;
      code_ext_q    <= code_ext_d;
      code_break_q  <= code_break_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign key_down    = key_down_q;
  assign key_press   = key_press_q;
  assign key_release = key_release_q;
  assign code_valid  = code_valid_q;
  assign code_data   = code_data_q;
  assign code_ext    = code_ext_q;
  assign code_break  = code_break_q;
  assign frame_err   = frame_err_q;

endmodule : ps2_key_decoder

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: drives PS/2 frames bit by bit and
// checks decoded codes, key state and error pulses via pulse monitors.
module tb_ps2_key_decoder;

  localparam int unsigned TMO  = 100;
  localparam int unsigned HALF = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [5:0] key_down, key_press, key_release;
  logic       code_valid, code_ext, code_break, frame_err;
  logic [7:0] code_data;

  int n_cmp = 0;
  int n_bad = 0;

  // Pulse monitors (cumulative).
  int         n_cv = 0, n_fe = 0, n_orphan = 0;
  int         n_press [6];
  int         n_rel   [6];
  logic [7:0] last_data = '0;
  logic       last_ext = 1'b0, last_brk = 1'b0;

  // Snapshots taken before each scenario.
  int cv0, fe0;
  int p0 [6];
  int r0 [6];

  ps2_key_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .ps2_clk     (ps2_clk),
    .ps2_dat     (ps2_dat),
    .key_down    (key_down),
    .key_press   (key_press),
    .key_release (key_release),
    .code_valid  (code_valid),
    .code_data   (code_data),
    .code_ext    (code_ext),
    .code_break  (code_break),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 6; i++) begin
      n_press[i] = 0;
      n_rel[i]   = 0;
    end
  end

  always @(negedge clk) begin
    if (code_valid) begin
      n_cv++;
      last_data = code_data;
      last_ext  = code_ext;
      last_brk  = code_break;
    end
    if (frame_err) n_fe++;
    if ((key_press != 0 || key_release != 0) && !code_valid) n_orphan++;
    for (int i = 0; i < 6; i++) begin
      if (key_press[i])   n_press[i]++;
      if (key_release[i]) n_rel[i]++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    cv0 = n_cv;
    fe0 = n_fe;
    for (int i = 0; i < 6; i++) begin
      p0[i] = n_press[i];
      r0[i] = n_rel[i];
    end
  endtask

  task automatic ps2_bit(input logic b);
    ps2_dat = b;
    repeat (HALF) @(posedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(posedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input logic bad_par,
                      input logic bad_stop);
    logic par;
    par = ~(^b) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(~bad_stop);
    ps2_dat = 1'b1;
    repeat (12) @(posedge clk);
  endtask

  initial begin
    repeat (4) @(posedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_key_down",   32'(key_down), 32'h0);
    check_eq("rst_code_data",  32'(code_data), 32'h0);
    check_eq("rst_code_valid", 32'(code_valid), 32'h0);
    check_eq("rst_flags",      32'({code_ext, code_break, frame_err}), 32'h0);

    // Space make.
    snap();
    send(8'h29, 1'b0, 1'b0);
    check_eq("space_cv",    32'(n_cv - cv0), 32'd1);
    check_eq("space_data",  32'(last_data), 32'h29);
    check_eq("space_ext",   32'(last_ext), 32'h0);
    check_eq("space_press", 32'(n_press[5] - p0[5]), 32'd1);
    check_eq("space_down",  32'(key_down), 32'h20);

    // Up: make, typematic repeat, break.
    snap();
    send(8'hE0, 1'b0, 1'b0); send(8'h75, 1'b0, 1'b0);
    send(8'hE0, 1'b0, 1'b0); send(8'h75, 1'b0, 1'b0);
    check_eq("up_press_once", 32'(n_press[3] - p0[3]), 32'd1);
    send(8'hE0, 1'b0, 1'b0); send(8'hF0, 1'b0, 1'b0); send(8'h75, 1'b0, 1'b0);
    check_eq("up_cv",       32'(n_cv - cv0), 32'd3);
    check_eq("up_press",    32'(n_press[3] - p0[3]), 32'd1);
    check_eq("up_release",  32'(n_rel[3] - r0[3]), 32'd1);
    check_eq("up_down",     32'(key_down), 32'h20);
    check_eq("up_brk_ext",  32'({last_brk, last_ext}), 32'h3);

    // Space break, then unmapped code.
    snap();
    send(8'hF0, 1'b0, 1'b0); send(8'h29, 1'b0, 1'b0);
    check_eq("space_rel",   32'(n_rel[5] - r0[5]), 32'd1);
    check_eq("space_up",    32'(key_down), 32'h0);
    snap();
    send(8'h1C, 1'b0, 1'b0);
    check_eq("unm_cv",      32'(n_cv - cv0), 32'd1);
    check_eq("unm_data",    32'(last_data), 32'h1C);
    check_eq("unm_brk",     32'(last_brk), 32'h0);
    check_eq("unm_down",    32'(key_down), 32'h0);

    // Bad stop bit clears a pending E0 prefix.
    snap();
    send(8'hE0, 1'b0, 1'b0); send(8'h29, 1'b0, 1'b1); send(8'h75, 1'b0, 1'b0);
    check_eq("stop_ferr",   32'(n_fe - fe0), 32'd1);
    check_eq("stop_cv",     32'(n_cv - cv0), 32'd1);
    check_eq("stop_ext",    32'({last_ext, last_data}), 32'h075);
    check_eq("stop_press",  32'(n_press[3] - p0[3]), 32'd0);

    // Timeout after start + 4 data bits, then a clean C.
    snap();
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    ps2_dat = 1'b1;
    repeat (TMO + 60) @(posedge clk);
    check_eq("tmo_ferr",    32'(n_fe - fe0), 32'd1);
    check_eq("tmo_cv",      32'(n_cv - cv0), 32'd0);
    send(8'h21, 1'b0, 1'b0);
    check_eq("tmo_c_press", 32'(n_press[4] - p0[4]), 32'd1);
    check_eq("tmo_c_data",  32'(last_data), 32'h21);
    check_eq("tmo_c_down",  32'(key_down), 32'h10);

    // Wrong parity on space.
    snap();
    send(8'h29, 1'b1, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
    check_eq("par_ferr",    32'(n_fe - fe0), 32'd1);
    check_eq("par_cv",      32'(n_cv - cv0), 32'd0);
`else
    check_eq("par_ferr",    32'(n_fe - fe0), 32'd0);
    check_eq("par_cv",      32'(n_cv - cv0), 32'd1);
    check_eq("par_data",    32'(last_data), 32'h29);
`endif

    // Reset in the middle of a C frame.
    snap();
    ps2_bit(1'b0);
    ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b0);
    @(posedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("mrst_down",   32'(key_down), 32'h0);
    check_eq("mrst_data",   32'(code_data), 32'h0);
    reset = 1'b0;
    repeat (TMO + 60) @(posedge clk);
    check_eq("mrst_ferr",   32'(n_fe - fe0), 32'd0);
    snap();
    send(8'h21, 1'b0, 1'b0);
    check_eq("mrst_press",  32'(n_press[4] - p0[4]), 32'd1);
    check_eq("mrst_cdown",  32'(key_down), 32'h10);

    check_eq("orphan_pulses", 32'(n_orphan), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_ps2_key_decoder
